// File: rtl/npu_seq_ctrl.sv
// npu_seq_ctrl: layer-pass sequencer for the NPU datapath.
// Drives buffer, MAC, ReLU, PISO and output FIFO strobes from START.
module npu_seq_ctrl #(
    parameter int PISO_BYTES = 8,
    parameter int ACC_W      = 8
) (
    input  logic             CLKEXT,
    input  logic             RST_GLO,
    input  logic             START,
    input  logic             ABORT,
    input  logic [ACC_W-1:0] NUM_ACC,
    input  logic             IN_VALID,
    input  logic             FULL,
    output logic             IN_READY,
    output logic             EN_BUF_IN,
    output logic             CLR_BUF_IN,
    output logic             EN_MAC,
    output logic             RST_MAC,
    output logic             EN_ReLU,
    output logic             EN_PISO_OUT,
    output logic             CLR_PISO_OUT,
    output logic             SHIFT_OUT,
    output logic             WR_EN,
    output logic             BUSY,
    output logic             OUT_DONE,
    output logic [ACC_W-1:0] CTR_OUT
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_DRAIN,
        S_RELU,
        S_CAPT,
        S_SHIFT,
        S_DONE,
        S_ABRT
    } state_t;

    localparam logic [ACC_W-1:0] LAST_BYTE = ACC_W'(PISO_BYTES - 1);

    state_t           r_state;
    logic [ACC_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc_n;
    logic             r_en_mac;

    logic w_abort;
    logic w_load;
    logic w_write;

    // ABORT only matters while a pass is actually in flight
    always_comb begin
        w_abort = 1'b0;
        unique case (r_state)
            S_CLR, S_LOAD, S_DRAIN, S_RELU,
            S_CAPT, S_SHIFT: w_abort = ABORT;
            default:         w_abort = 1'b0;
        endcase
    end

    assign w_load  = (r_state == S_LOAD) & IN_VALID;
    assign w_write = (r_state == S_SHIFT) & ~FULL;

    // State, counters and the one-cycle EN_MAC delay flop
    always_ff @(posedge CLKEXT) begin
        if (RST_GLO) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc_n  <= '0;
            r_en_mac <= 1'b0;
        end else begin
            r_en_mac <= w_load & ~w_abort;
            if (w_abort) begin
                r_state <= S_ABRT;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (START) begin
                            r_state <= S_CLR;
                            r_acc_n <= NUM_ACC;
                            r_cnt   <= '0;
                        end
                    end
                    S_CLR: begin
                        r_state <= (r_acc_n != '0) ? S_LOAD : S_RELU;
                    end
                    S_LOAD: begin
                        if (IN_VALID) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == r_acc_n - 1'b1)
                                r_state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: r_state <= S_RELU;
                    S_RELU:  r_state <= S_CAPT;
                    S_CAPT: begin
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (!FULL) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt == LAST_BYTE)
                                r_state <= S_DONE;
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    S_ABRT:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Moore strobe decode; EN_BUF_IN and WR_EN/SHIFT_OUT are input-qualified
    always_comb begin
        IN_READY     = (r_state == S_LOAD);
        EN_BUF_IN    = w_load;
        CLR_BUF_IN   = (r_state == S_CLR) | (r_state == S_ABRT);
        RST_MAC      = (r_state == S_CLR) | (r_state == S_ABRT);
        CLR_PISO_OUT = (r_state == S_CLR) | (r_state == S_ABRT);
        EN_ReLU      = (r_state == S_RELU);
        EN_PISO_OUT  = (r_state == S_CAPT);
        SHIFT_OUT    = w_write;
        WR_EN        = w_write;
        BUSY         = (r_state != S_IDLE);
        OUT_DONE     = (r_state == S_DONE);
        EN_MAC       = r_en_mac;
        CTR_OUT      = r_cnt;
    end

endmodule
